// File: rtl/demux_l1_pkg.sv
// rtl/demux_l1_pkg.sv - shared constants and types for the layer-1 receive demux
package demux_l1_pkg;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam int   VALID_HOLD_DEF = 2;
  localparam logic RESET_ACTIVE   = 1'b0;
  localparam int   NUM_LANES      = 2;

  // Lane phase: which half of the interleaved pair the next valid word is.
  typedef enum logic {
    SEL_EVEN = 1'b0,
    SEL_ODD  = 1'b1
  } sel_e;

  // Width needed to hold the count VALID_HOLD (never narrower than one bit).
  function automatic int hold_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/demux_1x2.sv
// rtl/demux_1x2.sv - one lane: splits an alternating word stream into an even/odd pair
// Optional DEMUXL1_IDLE_ZERO_EN clears the pair when its valid window expires.
module demux_1x2
  import demux_l1_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VALID_HOLD = VALID_HOLD_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic [DATA_WIDTH-1:0] o_even,
  output logic [DATA_WIDTH-1:0] o_odd,
  output logic                  o_valid
);

  localparam int              HCW       = hold_width(VALID_HOLD);
  localparam logic [HCW-1:0]  HOLD_LOAD = HCW'(VALID_HOLD);
  localparam logic [HCW-1:0]  HOLD_ONE  = HCW'(1);

  sel_e                  r_sel;
  sel_e                  w_sel_nxt;
  logic                  w_stage_load;
  logic                  w_pair_done;
  logic [DATA_WIDTH-1:0] r_stage;
  logic [DATA_WIDTH-1:0] r_even;
  logic [DATA_WIDTH-1:0] r_odd;
  logic [HCW-1:0]        r_hold;

  always_ff @(posedge i_clk) begin
    if (i_reset_n == RESET_ACTIVE) begin
      r_sel <= SEL_EVEN;
    end else begin
      r_sel <= w_sel_nxt;
    end
  end

  // Idle cycles leave the phase alone, so a half pair waits for its partner.
  always_comb begin
    w_sel_nxt    = r_sel;
    w_stage_load = 1'b0;
    w_pair_done  = 1'b0;
    case (r_sel)
      SEL_EVEN: begin
        if (i_valid) begin
          w_stage_load = 1'b1;
          w_sel_nxt    = SEL_ODD;
        end
      end
      SEL_ODD: begin
        if (i_valid) begin
          w_pair_done = 1'b1;
          w_sel_nxt   = SEL_EVEN;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n == RESET_ACTIVE) begin
      r_stage <= '0;
      r_even  <= '0;
      r_odd   <= '0;
      r_hold  <= '0;
    end else begin
      if (w_stage_load) begin
        r_stage <= i_data;
      end
      if (w_pair_done) begin
        r_even <= r_stage;
        r_odd  <= i_data;
        r_hold <= HOLD_LOAD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HOLD_ONE;
`ifdef DEMUXL1_IDLE_ZERO_EN
        if (r_hold == HOLD_ONE) begin
          r_even <= '0;
          r_odd  <= '0;
        end
`endif
      end
    end
  end

  assign o_even  = r_even;
  assign o_odd   = r_odd;
  assign o_valid = (r_hold != '0);

endmodule

// File: rtl/demux_l1.sv
// rtl/demux_l1.sv - two-lane layer-1 receive demux (four outputs), clk_2f domain
// Optional DEMUXL1_IDLE_ZERO_EN: zero each lane's outputs when its valid drops.
module demux_l1
  import demux_l1_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VALID_HOLD = VALID_HOLD_DEF
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Entrada0,
  input  logic [DATA_WIDTH-1:0] Entrada1,
  input  logic                  validEntrada0,
  input  logic                  validEntrada1,
  output logic [DATA_WIDTH-1:0] Salida0,
  output logic [DATA_WIDTH-1:0] Salida1,
  output logic [DATA_WIDTH-1:0] Salida2,
  output logic [DATA_WIDTH-1:0] Salida3,
  output logic                  validSalida0,
  output logic                  validSalida1,
  output logic                  validSalida2,
  output logic                  validSalida3
);

  logic [DATA_WIDTH-1:0] w_din  [NUM_LANES];
  logic                  w_vin  [NUM_LANES];
  logic [DATA_WIDTH-1:0] w_even [NUM_LANES];
  logic [DATA_WIDTH-1:0] w_odd  [NUM_LANES];
  logic                  w_vout [NUM_LANES];

  assign w_din[0] = Entrada0;
  assign w_din[1] = Entrada1;
  assign w_vin[0] = validEntrada0;
  assign w_vin[1] = validEntrada1;

  // Lanes share nothing but clock and reset; any inter-lane skew passes through.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_1x2 #(
      .DATA_WIDTH (DATA_WIDTH),
      .VALID_HOLD (VALID_HOLD)
    ) u_lane (
      .i_clk     (clk_2f),
      .i_reset_n (reset),
      .i_data    (w_din[g]),
      .i_valid   (w_vin[g]),
      .o_even    (w_even[g]),
      .o_odd     (w_odd[g]),
      .o_valid   (w_vout[g])
    );
  end

  assign Salida0      = w_even[0];
  assign Salida1      = w_odd[0];
  assign Salida2      = w_even[1];
  assign Salida3      = w_odd[1];
  assign validSalida0 = w_vout[0];
  assign validSalida1 = w_vout[0];
  assign validSalida2 = w_vout[1];
  assign validSalida3 = w_vout[1];

endmodule

// File: tb/tb_demux_l1.sv
// tb/tb_demux_l1.sv - scoreboard bench for demux_l1 with a behavioural pair/age model
module tb_demux_l1;

  localparam int DW = 8;
  localparam int VH = 2;

  logic          clk_2f = 1'b0;
  logic          reset  = 1'b0;
  logic [DW-1:0] Entrada0 = '0, Entrada1 = '0;
  logic          validEntrada0 = 1'b0, validEntrada1 = 1'b0;
  logic [DW-1:0] Salida0, Salida1, Salida2, Salida3;
  logic          validSalida0, validSalida1, validSalida2, validSalida3;

  demux_l1 #(.DATA_WIDTH(DW), .VALID_HOLD(VH)) dut (
    .clk_2f        (clk_2f),
    .reset         (reset),
    .Entrada0      (Entrada0),
    .Entrada1      (Entrada1),
    .validEntrada0 (validEntrada0),
    .validEntrada1 (validEntrada1),
    .Salida0       (Salida0),
    .Salida1       (Salida1),
    .Salida2       (Salida2),
    .Salida3       (Salida3),
    .validSalida0  (validSalida0),
    .validSalida1  (validSalida1),
    .validSalida2  (validSalida2),
    .validSalida3  (validSalida3)
  );

  always #5 clk_2f = ~clk_2f;

`ifdef DEMUXL1_IDLE_ZERO_EN
  localparam bit IDLE_ZERO = 1'b1;
`else
  localparam bit IDLE_ZERO = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] s0, s1, s2, s3;
    logic          v01, v23;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Model: words received since reset, last completed pair, edges since it completed.
  int            m_words [2];
  logic [DW-1:0] m_half  [2];
  logic [DW-1:0] m_even  [2];
  logic [DW-1:0] m_odd   [2];
  bit            m_seen  [2];
  int            m_age   [2];

  task automatic chk(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %h required %h", name, c, act, req);
  endtask

  function automatic void model_lane(input int l, input bit rst, input bit v, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    if (rst) begin
      m_words[l] = 0; m_seen[l] = 1'b0; m_age[l] = 0;
      m_half[l] = '0; m_even[l] = '0; m_odd[l] = '0;
      return;
    end
    if (v) begin
      if (m_words[l] % 2 == 0) m_half[l] = d;
      else begin
        m_even[l] = m_half[l]; m_odd[l] = d;
        m_seen[l] = 1'b1; m_age[l] = 0; done = 1'b1;
      end
      m_words[l]++;
    end
    if (!done && m_seen[l] && m_age[l] < 1000) m_age[l]++;
  endfunction

  function automatic logic exp_valid(input int l);
    return m_seen[l] && (m_age[l] < VH);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int l, input bit odd);
    if (IDLE_ZERO && m_seen[l] && m_age[l] >= VH) return '0;
    return odd ? m_odd[l] : m_even[l];
  endfunction

  // Drive one cycle at the negedge and push the state expected after the next posedge.
  task automatic step(input bit rstn, input bit v0, input logic [DW-1:0] d0,
                      input bit v1, input logic [DW-1:0] d1);
    exp_t e;
    @(negedge clk_2f);
    reset = rstn;
    validEntrada0 = v0; Entrada0 = d0;
    validEntrada1 = v1; Entrada1 = d1;
    model_lane(0, !rstn, v0, d0);
    model_lane(1, !rstn, v1, d1);
    e.s0 = exp_data(0, 1'b0); e.s1 = exp_data(0, 1'b1);
    e.s2 = exp_data(1, 1'b0); e.s3 = exp_data(1, 1'b1);
    e.v01 = exp_valid(0); e.v23 = exp_valid(1);
    e.cyc = cyc;
    cyc++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_2f);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("Salida0", e.cyc, Salida0, e.s0);
        chk("Salida1", e.cyc, Salida1, e.s1);
        chk("Salida2", e.cyc, Salida2, e.s2);
        chk("Salida3", e.cyc, Salida3, e.s3);
        chk("validSalida0", e.cyc, {7'd0, validSalida0}, {7'd0, e.v01});
        chk("validSalida1", e.cyc, {7'd0, validSalida1}, {7'd0, e.v01});
        chk("validSalida2", e.cyc, {7'd0, validSalida2}, {7'd0, e.v23});
        chk("validSalida3", e.cyc, {7'd0, validSalida3}, {7'd0, e.v23});
      end
    end
  end

  initial begin : driver
    int pending;
    for (int l = 0; l < 2; l++) model_lane(l, 1'b1, 1'b0, '0);

    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(2);

    step(1'b1, 1'b1, 8'h11, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h22, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h33, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h44, 1'b0, 8'h00);
    idle(3);

    step(1'b1, 1'b0, 8'h00, 1'b1, 8'hA5);
    idle(2);
    step(1'b1, 1'b0, 8'h00, 1'b1, 8'h5A);
    idle(3);

    step(1'b1, 1'b1, 8'hC3, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h01, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h02, 1'b0, 8'h00);
    idle(3);

    step(1'b1, 1'b1, 8'h10, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h20, 1'b1, 8'h30);
    step(1'b1, 1'b0, 8'h00, 1'b1, 8'h40);
    idle(3);

    step(1'b1, 1'b1, 8'h7E, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h81, 1'b0, 8'h00);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 9) < 6), 8'($urandom),
           ($urandom_range(0, 9) < 5), 8'($urandom));
      if ($urandom_range(0, 29) == 0) idle($urandom_range(1, 4));
    end
    idle(4);

    repeat (3) @(posedge clk_2f);
    #3;
    pending = exp_q.size();
    chk("scoreboard_drained", cyc, 8'(pending), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
